// File: rtl/vx_weighted_fair_arbiter_pkg.sv
// Shared definitions for the weighted fair arbiter.
//  - VX_WFA_SLOT_T(W): per-requester round state {elig, credit[W]}. It is a
//    macro because a package typedef cannot take the module's WEIGHT_W.
//  - wfa_log_reqs(): grant_index width, kept >=1 so NUM_REQS==1 still has a port.
//  - wfa_weight_lsb(): lsb of weight field idx inside the flat weights bus.
// Optional feature macro: VX_WFA_PERF_EN (perf_rounds counter on the top).
`ifndef VX_WFA_SLOT_T
`define VX_WFA_SLOT_T(W) struct packed { logic elig; logic [(W)-1:0] credit; }
`endif

package vx_weighted_fair_arbiter_pkg;

  localparam int WFA_NUM_REQS_DEF = 4;
  localparam int WFA_WEIGHT_W_DEF = 2;

  function automatic int wfa_log_reqs(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wfa_weight_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/vx_weighted_fair_arbiter_if.sv
// Request/grant bundle of the weighted fair arbiter.
//  master : requester side, drives enable/requests/weights, sees the grant.
//  slave  : arbiter side, consumes requests, drives grant_* and round_start.
interface vx_weighted_fair_arbiter_if
  import vx_weighted_fair_arbiter_pkg::*;
#(
  parameter int NUM_REQS     = WFA_NUM_REQS_DEF,
  parameter int WEIGHT_W     = WFA_WEIGHT_W_DEF,
  parameter int LOG_NUM_REQS = wfa_log_reqs(NUM_REQS)
) ();

  logic                         enable;
  logic [NUM_REQS-1:0]          requests;
  logic [NUM_REQS*WEIGHT_W-1:0] weights;
  logic [LOG_NUM_REQS-1:0]      grant_index;
  logic [NUM_REQS-1:0]          grant_onehot;
  logic                         grant_valid;
  logic                         round_start;

  modport master (
    output enable, requests, weights,
    input  grant_index, grant_onehot, grant_valid, round_start
  );

  modport slave (
    input  enable, requests, weights,
    output grant_index, grant_onehot, grant_valid, round_start
  );

endinterface

// File: rtl/vx_weighted_fair_arbiter_credit_slot.sv
// One requester's round state.
//  clk, reset_n : clock, synchronous active-low reset (elig=1, credit=0)
//  restart      : this grant opens a new round (reload weight, re-arm elig)
//  win          : this slot is the current winner
//  advance      : grant accepted, state may move
//  weight       : per-requester weight, sampled only on restart
//  elig, credit : registered state
module vx_weighted_fair_arbiter_credit_slot
  import vx_weighted_fair_arbiter_pkg::*;
#(
  parameter int WEIGHT_W = WFA_WEIGHT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                restart,
  input  logic                win,
  input  logic                advance,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                elig,
  output logic [WEIGHT_W-1:0] credit
);

  typedef `VX_WFA_SLOT_T(WEIGHT_W) wfa_slot_t;

  wfa_slot_t           st_q, st_d;
  logic [WEIGHT_W-1:0] cur_credit;
  logic                cur_elig;

  always_comb begin
    cur_credit = restart ? weight : st_q.credit;
    cur_elig   = restart | st_q.elig;
    st_d       = st_q;
    if (advance) begin
      st_d.elig   = cur_elig;
      st_d.credit = cur_credit;
      // credit counts remaining extra grants; at zero the slot retires
      // for the rest of the round instead of underflowing
      if (win) begin
        if (cur_credit == '0) st_d.elig   = 1'b0;
        else                  st_d.credit = cur_credit - WEIGHT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q.elig   <= 1'b1;
      st_q.credit <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign elig   = st_q.elig;
  assign credit = st_q.credit;

endmodule

// File: rtl/vx_weighted_fair_arbiter.sv
// Round-based weighted fair arbiter with zero-latency grant.
// Each requester gets up to weight+1 grants per round; inside a round the
// lowest eligible live index wins. When no live requester is eligible the
// next grant restarts the round (no bubble).
//  clk         : clock
//  reset_n     : synchronous active-low reset; grant outputs forced 0 while low
//  arb_if      : slave side of the request/grant bundle
//  perf_rounds : rounds started, wraps (only with VX_WFA_PERF_EN defined)
module vx_weighted_fair_arbiter
  import vx_weighted_fair_arbiter_pkg::*;
#(
  parameter int NUM_REQS     = WFA_NUM_REQS_DEF,
  parameter int WEIGHT_W     = WFA_WEIGHT_W_DEF,
  parameter int LOCK_ENABLE  = 0,
  parameter int LOG_NUM_REQS = wfa_log_reqs(NUM_REQS),
  parameter int PERF_CTR_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vx_weighted_fair_arbiter_if.slave arb_if
`ifdef VX_WFA_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0]  perf_rounds
`endif
);

  logic [NUM_REQS-1:0]               elig;
  logic [NUM_REQS-1:0][WEIGHT_W-1:0] credit;
  logic [NUM_REQS-1:0]               live, qual, win_oh;
  logic [LOG_NUM_REQS-1:0]           win_idx;
  logic                              in_round, restart, grant_valid, advance;

  assign live    = arb_if.requests & elig;
  assign restart = !in_round || (live == '0);
  assign qual    = restart ? arb_if.requests : live;

  // fixed priority: lowest set index of qual
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (qual[i]) begin
        win_idx = LOG_NUM_REQS'(i);
        win_oh  = NUM_REQS'(1) << i;
      end
    end
  end

  // qual is non-empty whenever requests is, so |requests is the valid
  assign grant_valid = reset_n && (|arb_if.requests);
  assign advance     = grant_valid && ((LOCK_ENABLE == 0) || arb_if.enable);

  assign arb_if.grant_valid  = grant_valid;
  assign arb_if.grant_index  = grant_valid ? win_idx : '0;
  assign arb_if.grant_onehot = grant_valid ? win_oh : '0;
  assign arb_if.round_start  = grant_valid && restart;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_slot
    localparam int LSB = wfa_weight_lsb(i, WEIGHT_W);
    vx_weighted_fair_arbiter_credit_slot #(
      .WEIGHT_W (WEIGHT_W)
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart),
      .win     (win_oh[i]),
      .advance (advance),
      .weight  (arb_if.weights[LSB +: WEIGHT_W]),
      .elig    (elig[i]),
      .credit  (credit[i])
    );
  end

  // credit only matters inside the slots; exposed for debug visibility
  logic unused_credit;
  assign unused_credit = ^credit;

  always_ff @(posedge clk) begin
    if (!reset_n)     in_round <= 1'b0;
    else if (advance) in_round <= 1'b1;
  end

`ifdef VX_WFA_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                perf_rounds <= '0;
    else if (advance && restart) perf_rounds <= perf_rounds + PERF_CTR_W'(1);
  end
`endif

endmodule
